// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type codes, field-position helpers, route width and the
// input-port FSM state encoding. The output-port stage imports the same package so that
// both ends decode flit headers the same way.
//
// Flit layout (FLIT_WIDTH bits, MSB first):
//   [W-1:W-2] flit type  (01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE)
//   [W-3:W-4] destination port (meaningful only in HEAD and SINGLE)
//   [W-5:0]   payload
package noc_pkg;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam int unsigned ROUTE_WIDTH = 2;
  localparam int unsigned NUM_PORTS   = 4;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } port_state_e;

  // Bit position of the LSB of the type field for a given flit width.
  function automatic int unsigned type_lsb(input int unsigned flit_width);
    return flit_width - 2;
  endfunction

  // Bit position of the LSB of the destination field for a given flit width.
  function automatic int unsigned dest_lsb(input int unsigned flit_width);
    return flit_width - 4;
  endfunction

  // True for flits that open a packet and carry a route.
  function automatic logic is_head_type(input logic [1:0] ftype);
    return (ftype == FT_HEAD) || (ftype == FT_SINGLE);
  endfunction

  // True for flits that close a packet.
  function automatic logic is_tail_type(input logic [1:0] ftype);
    return (ftype == FT_TAIL) || (ftype == FT_SINGLE);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small synchronous FIFO for flits with a registered occupancy count.
// The oldest entry is always visible on dout (first-word fall-through); dout is
// meaningless while empty is high.
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset; empties the FIFO
//   push   write din at the tail (ignored when full)
//   din    data to write
//   pop    discard the head entry (ignored when empty)
//   dout   head entry
//   full   count == DEPTH
//   empty  count == 0
module flit_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally on overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout = mem_q[rd_ptr_q];

endmodule

// File: rtl/input_port.sv
// Router input stage. Buffers flits from one link, computes the route once per packet from
// the head flit, then streams the packet wormhole-style, tagging each flit with a valid bit
// and the 2-bit destination port. Orphan BODY/TAIL flits seen outside a packet are dropped
// and counted.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream flit present
//   in_flit     incoming flit
//   in_ready    FIFO can accept this cycle (depends only on registered count)
//   block_in    per-output-port block, bit i from output port i
//   data_out    {valid, route, flit}; all-zero when not valid
//   drop_count  saturating count of dropped orphan flits
module input_port
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic                  in_ready,
  input  logic [NUM_PORTS-1:0]  block_in,
  output logic [FLIT_WIDTH+2:0] data_out,
  output logic [7:0]            drop_count
);

  localparam int unsigned TypeLsb = type_lsb(FLIT_WIDTH);
  localparam int unsigned DestLsb = dest_lsb(FLIT_WIDTH);

  logic [FLIT_WIDTH-1:0]  fifo_head;
  logic                   fifo_full, fifo_empty;
  logic                   fifo_push, fifo_pop;
  logic [1:0]             head_type;
  logic                   out_valid;

  port_state_e            state_q, state_d;
  logic [ROUTE_WIDTH-1:0] route_q, route_d;
  logic [7:0]             drop_q, drop_d;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  flit_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (in_flit),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_type = fifo_head[TypeLsb +: 2];

  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    drop_d    = drop_q;
    fifo_pop  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          if (is_head_type(head_type)) begin
            // Route compute cycle: the head stays in the FIFO and is sent from StActive.
            route_d = fifo_head[DestLsb +: ROUTE_WIDTH];
            state_d = StActive;
          end else begin
            // Orphan BODY/TAIL outside any packet.
            fifo_pop = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end
        end
      end
      StActive: begin
        // A HEAD seen here is just payload; the route is held until the tail leaves.
        out_valid = !fifo_empty;
        if (out_valid && !block_in[route_q]) begin
          fifo_pop = 1'b1;
          if (is_tail_type(head_type)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      route_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      drop_q  <= drop_d;
    end
  end

  assign data_out   = out_valid ? {1'b1, route_q, fifo_head} : '0;
  assign drop_count = drop_q;

endmodule

// File: doc/input_port.md
# input_port

Router input stage. Accepts flits from one link, buffers them in a small FIFO, and computes the route once per packet from the head flit. It then streams the packet wormhole-style to the output ports, tagging each flit with a 2-bit destination-port header and valid bit. It stalls whenever the selected output port blocks it; four instances feed the four-input output-port stage.

## Interface
- FLIT_WIDTH, 16: raw flit width; must be at least 6.
- DEPTH, 4: FIFO depth in flits; must be a power of two, at least 2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream flit present.
- in_flit  in  FLIT_WIDTH  incoming flit.
- in_ready  out  1  FIFO can accept this cycle.
- block_in  in  4  per-output-port block, bit i from output port i; 1 means not granted this cycle.
- data_out  out  FLIT_WIDTH+3  tagged flit: [FLIT_WIDTH+2] valid, [FLIT_WIDTH+1:FLIT_WIDTH] route, [FLIT_WIDTH-1:0] flit.
- drop_count  out  8  saturating count of dropped orphan flits.

## Operation
- Flit type is in [FLIT_WIDTH-1:FLIT_WIDTH-2]:
  - 01 HEAD
  - 00 BODY
  - 10 TAIL
  - 11 SINGLE (head and tail)
- Destination port is in [FLIT_WIDTH-3:FLIT_WIDTH-4]; it is meaningful only in HEAD and SINGLE flits.
- Push: in_valid && in_ready at a clock edge writes in_flit to the FIFO tail.
- in_ready = !full. It is a function of the registered count only, so no push happens when full, even if a pop occurs in the same cycle.
- FSM state IDLE:
  - FIFO empty: nothing happens.
  - FIFO head is HEAD or SINGLE: load route_q from the dest field and go to ACTIVE. There is no pop this cycle.
  - FIFO head is BODY or TAIL (orphan): pop it, increment drop_count (saturating at 255), stay in IDLE.
- FSM state ACTIVE:
  - data_out = {fifo_nonempty, route_q, fifo_head}.
  - Pop when fifo_nonempty && !block_in[route_q].
  - Popping a TAIL or SINGLE flit returns the FSM to IDLE.
  - Popping HEAD or BODY keeps ACTIVE.
  - A HEAD arriving mid-packet is forwarded as data and does not reroute.
- data_out is all-zero whenever its valid bit is 0.
- Simultaneous push and pop: count is unchanged, pointers both advance.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.

## Timing
- Reset values:
  - state IDLE, FIFO empty, route_q 0, drop_count 0.
  - data_out 0, in_ready 1 (the first cycle after reset).
- Reset mid-packet discards all buffered flits and any partial packet with no further output.
- Head-flit latency, flit accepted at edge E0:
  - route_q loaded at E1.
  - data_out valid from E1 to E2.
  - Popped at E2 if unblocked.
- Body and tail flits stream one per cycle while unblocked. There is no bubble between flits of one packet.
- One dead cycle (route compute) occurs between the tail of one packet and the first valid cycle of the next.
- Blocked: data_out holds the same flit and valid stays 1 until the cycle block_in[route_q] is 0.
- Orphan drop takes one cycle per flit.

## Structure
- Shared package noc_pkg:
  - flit-type localparams FT_HEAD, FT_BODY, FT_TAIL, FT_SINGLE.
  - type and dest field position helpers.
  - FSM state encoding (IDLE, ACTIVE).
  - route width constant 2.
  - The output port imports the same package for header decode.
- Sub-module flit_fifo (parameters WIDTH, DEPTH):
  - ports clk, rst, push, din, pop, dout, full, empty.
  - registered count, first-word visible on dout.
- input_port contains the FSM, route register, output tagging, and drop counter.

## Test plan
- SINGLE flit to dest 2, block_in=0: data_out valid 2 cycles after acceptance with route 2; valid for one cycle; FSM back to IDLE.
- 3-flit packet (HEAD dest 1, BODY, TAIL), block_in[1]=1 for 3 cycles during BODY: BODY held stable with valid=1 throughout; TAIL follows in the next unblocked cycle; block_in[0,2,3] toggling has no effect.
- Push 5 flits with DEPTH=4 while blocked: in_ready drops to 0 after 4 pushes; the 5th is accepted only the cycle after the first pop; no flit lost or reordered.
- BODY 0x0123 then TAIL arriving in IDLE, then SINGLE dest 3: drop_count reaches 2; only the SINGLE appears on data_out, with route 3.
- rst asserted one cycle mid-packet with 2 flits buffered: next cycle data_out=0, in_ready=1, drop_count=0; a following new packet routes correctly.
- Back-to-back packets dest 0 then dest 3: exactly one invalid cycle between the first TAIL and the second HEAD; route changes 0→3.
